event_capture_fifo: RTL and testbench
=====================================

EVENT_CAPTURE_FIFO -- requirements
Module: event_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 2, captured data width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter CNT_W, default 8, width of the sequence and drop counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port trig_i, input, 1, capture request for the current cycle.
REQ-007 SHALL have port data_i, input, DATA_W, value to capture.
REQ-008 SHALL have port valid_o, output, 1, FIFO head holds a captured entry.
REQ-009 SHALL have port ready_i, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port data_o, output, DATA_W, head entry data.
REQ-011 SHALL have port seq_o, output, CNT_W, head entry sequence number.
REQ-012 SHALL have port level_o, output, clog2(DEPTH)+1, current occupancy.
REQ-013 SHALL have port drop_cnt_o, output, CNT_W, count of rejected captures.
REQ-014 SHALL have port overflow_o, output, 1, sticky flag, set on the first rejected capture.
REQ-015 SHALL have port clr_i, input, 1, synchronous clear of drop_cnt_o and overflow_o.

Function
REQ-016 SHALL capture {data_i, seq} on a rising edge with trig_i=1 when not full or when a pop occurs in the same cycle.
REQ-017 SHALL sample data_i only at the edge: changes to data_i after the edge in the same timestep SHALL NOT affect the stored entry.
REQ-018 SHALL assign seq from an internal CNT_W counter starting at 0, incremented by 1 per accepted capture, wrapping from 2^CNT_W-1 to 0.
REQ-019 SHALL pop the head when valid_o=1 and ready_i=1 at a rising edge.
REQ-020 SHALL drive valid_o, data_o and seq_o from registers; capture-to-valid_o latency of 1 cycle when the FIFO is empty; no combinational path from trig_i or data_i to outputs.
REQ-021 SHALL hold data_o and seq_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL reject trig_i=1 when full and no pop occurs in that cycle: FIFO unchanged; seq counter not incremented; drop_cnt_o increments and saturates at 2^CNT_W-1; overflow_o set.
REQ-023 SHALL accept the capture when full with a simultaneous pop: level_o unchanged; new entry at tail.
REQ-024 SHALL, on simultaneous push and pop when level_o=1, present the new entry as head in the next cycle with valid_o=1 continuously.
REQ-025 SHALL ignore ready_i when valid_o=0.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; level_o always in range 0..DEPTH.
REQ-027 SHALL, on clr_i=1, zero drop_cnt_o and clear overflow_o; a rejection in the same cycle as clr_i=1 SHALL leave drop_cnt_o=1 and overflow_o=1.
REQ-028 SHALL NOT let clr_i affect FIFO contents, pointers or the seq counter.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force valid_o=0, data_o=0, seq_o=0, level_o=0, drop_cnt_o=0, overflow_o=0, pointers=0, seq counter=0.
REQ-030 SHALL discard all stored entries when reset asserts mid-operation; the first capture after release SHALL carry seq=0.
REQ-031 SHALL ignore trig_i and ready_i on the first rising edge at which rst_n is still low; the first capture SHALL occur on the first edge with rst_n=1.

Verification
REQ-032 Single capture: data_i changes 1->2 in the same timestep as the clk rise with trig_i=1 -> stored entry is the value present before the edge (1), seq_o=0, valid_o=1 one cycle later.
REQ-033 Fill: 4 triggers, data 0,1,2,3, ready_i=0 -> level_o=4; 5th trigger -> drop_cnt_o=1, overflow_o=1; drain yields data 0,1,2,3 with seq 0,1,2,3.
REQ-034 Full plus simultaneous push and pop: level_o stays 4, drop_cnt_o unchanged, popped seq 0, new tail seq 4.
REQ-035 Backpressure: ready_i toggles 1,0,0,1 -> head data/seq held across both stall cycles; no loss, no duplicate.
REQ-036 Reset mid-stream at level_o=3 -> all outputs 0 immediately; next capture has seq_o=0.
REQ-037 Saturation/wrap with CNT_W=2: 5 rejections -> drop_cnt_o=3; 5 accepted captures -> seq sequence 0,1,2,3,0.

Source files
------------

// File: rtl/event_capture_fifo.sv
// Event capture FIFO: records {data, sequence number} on each trigger, drops
// and counts triggers that arrive while full with no pop in the same cycle.
module event_capture_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DATA_W-1:0]        data_o,
  output logic [CNT_W-1:0]         seq_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o,
  input  logic                     clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] dmem_q [DEPTH];
  logic [CNT_W-1:0]  smem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic [CNT_W-1:0]  seq_q, seq_d, drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push, drop;

  // A pop frees the slot in the same edge, so a full FIFO still accepts then.
  assign full = (level_q == FULL_LVL);
  assign pop  = (level_q != '0) && ready_i;
  assign push = trig_i && (!full || pop);
  assign drop = trig_i && full && !pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
      seq_d  = seq_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A rejection coincident with clear survives it as the first new drop.
    if (clr_i) begin
      drop_d = drop ? CNT_W'(1) : '0;
      ovf_d  = drop;
    end else if (drop) begin
      if (drop_q != '1) drop_d = drop_q + 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is reset so the head outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dmem_q[i] <= '0;
        smem_q[i] <= '0;
      end
    end else if (push) begin
      dmem_q[wptr_q] <= data_i;
      smem_q[wptr_q] <= seq_q;
    end
  end

  assign valid_o    = (level_q != '0);
  assign data_o     = dmem_q[rptr_q];
  assign seq_o      = smem_q[rptr_q];
  assign level_o    = level_q;
  assign drop_cnt_o = drop_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_event_capture_fifo.sv
// Scoreboard bench for event_capture_fifo: directed stimulus pushes expected
// head entries; a negedge monitor checks every presented head against them.
module tb_event_capture_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig_i, ready_i, clr_i;
  logic [1:0] data_i;
  logic       valid_o, overflow_o;
  logic [1:0] data_o;
  logic [7:0] seq_o, drop_cnt_o;
  logic [2:0] level_o;

  logic       s_trig, s_ready, s_clr, s_valid, s_ovf;
  logic [1:0] s_data, s_data_o, s_seq, s_drop;
  logic [2:0] s_level;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [1:0] d; logic [7:0] s; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  event_capture_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .trig_i(trig_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .seq_o(seq_o),
    .level_o(level_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
    .clr_i(clr_i)
  );

  event_capture_fifo #(.DATA_W(2), .DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .trig_i(s_trig), .data_i(s_data),
    .valid_o(s_valid), .ready_i(s_ready), .data_o(s_data_o), .seq_o(s_seq),
    .level_o(s_level), .drop_cnt_o(s_drop), .overflow_o(s_ovf),
    .clr_i(s_clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] d, input logic [7:0] s);
    ent_t e;
    e.d = d;
    e.s = s;
    q.push_back(e);
  endtask

  // Inputs change 1 time unit after the edge and are seen at the next edge.
  task automatic drive(input logic t, input logic [1:0] d, input logic r, input logic c);
    trig_i  = t;
    data_i  = d;
    ready_i = r;
    clr_i   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, int'(valid_o), 0);
    chk({tag, " data"},  int'(data_o), 0);
    chk({tag, " seq"},   int'(seq_o), 0);
    chk({tag, " level"}, int'(level_o), 0);
    chk({tag, " drop"},  int'(drop_cnt_o), 0);
    chk({tag, " ovf"},   int'(overflow_o), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (q.size() == 0) begin
        chk("spurious head valid", 1, 0);
      end else begin
        chk("head data", int'(data_o), int'(q[0].d));
        chk("head seq",  int'(seq_o),  int'(q[0].s));
        if (ready_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    trig_i = 0; data_i = 0; ready_i = 0; clr_i = 0;
    s_trig = 0; s_data = 2'd1; s_ready = 0; s_clr = 0;
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Edge sampling: data_i moves 1->2 in the capturing timestep.
    data_i = 2'd1;
    trig_i = 1'b1;
    @(posedge clk);
    data_i <= 2'd2;
    push_exp(2'd1, 8'd0);
    #1 trig_i = 1'b0;
    chk("single valid", int'(valid_o), 1);
    chk("single level", int'(level_o), 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("single drained level", int'(level_o), 0);

    rst_n = 1'b0;
    #1 q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill, then reject one while full.
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 0, 0);
      push_exp(2'(i), 8'(i));
    end
    chk("fill level", int'(level_o), 4);
    drive(1, 2, 0, 0);
    chk("reject level", int'(level_o), 4);
    chk("reject drop", int'(drop_cnt_o), 1);
    chk("reject ovf", int'(overflow_o), 1);

    // Full with simultaneous pop: accepted at the tail.
    drive(1, 3, 1, 0);
    push_exp(2'd3, 8'd4);
    chk("full push+pop level", int'(level_o), 4);
    chk("full push+pop drop", int'(drop_cnt_o), 1);

    // Backpressure 1,0,0,1 then drain.
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("drain level", int'(level_o), 0);
    chk("drain scoreboard left", q.size(), 0);

    drive(0, 0, 0, 1);
    chk("clr drop", int'(drop_cnt_o), 0);
    chk("clr ovf", int'(overflow_o), 0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(3 - i), 0, 0);
      push_exp(2'(3 - i), 8'(5 + i));
    end
    drive(1, 1, 0, 1);
    chk("clr+reject drop", int'(drop_cnt_o), 1);
    chk("clr+reject ovf", int'(overflow_o), 1);
    chk("clr+reject level", int'(level_o), 4);

    // Mid-stream reset at level 3; trigger held through a reset edge.
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("pre-reset level", int'(level_o), 3);
    #2;
    rst_n = 1'b0;
    trig_i = 1'b1;
    data_i = 2'd3;
    #1;
    chk_zero("midreset");
    q.delete();
    @(posedge clk);
    #1;
    chk("trig in reset ignored", int'(level_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    push_exp(2'd3, 8'd0);
    #1 trig_i = 1'b0;
    chk("post-reset level", int'(level_o), 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("post-reset drained", int'(level_o), 0);

    // Narrow counters: drop saturation and seq wrap.
    s_trig = 1'b1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    s_trig = 1'b0;
    chk("sat drop", int'(s_drop), 3);
    chk("sat ovf", int'(s_ovf), 1);
    chk("sat level", int'(s_level), 4);
    s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("sat head valid", int'(s_valid), 1);
      chk("sat seq", int'(s_seq), k);
      @(posedge clk);
      #1;
    end
    s_ready = 1'b0;
    s_trig = 1'b1;
    @(posedge clk);
    #1 s_trig = 1'b0;
    chk("wrap valid", int'(s_valid), 1);
    chk("wrap seq", int'(s_seq), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
